// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one request
// outstanding to a variable-latency instruction memory, and buffers returned
// words with their PC and fall-through PC in a DEPTH-entry queue for decode.
// A redirect flushes the queue and discards a response that is still in flight.
module if_fetch_queue #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic                         imem_ready,
    input  logic                         imem_rvalid,
    input  logic [INST_W-1:0]            imem_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INST_W-1:0]            out_inst,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [ADDR_W-1:0]            out_after_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = $clog2(DEPTH+1);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] fpc_q,    fpc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              pending_q, pending_d;
    logic              discard_q, discard_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [INST_W-1:0] inst_d [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];
    logic [ADDR_W-1:0] apc_q  [DEPTH];
    logic [ADDR_W-1:0] apc_d  [DEPTH];

    logic [CNT_W:0]    occupancy;
    logic              accept;
    logic              resp;
    logic              push;
    logic              pop;

    // Outstanding work counts the in-flight request so a push can never hit a full queue.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q};
    assign imem_req  = rst & ~redirect & (occupancy < (CNT_W+1)'(DEPTH))
                     & (~pending_q | imem_rvalid);
    assign imem_addr = fpc_q;
    assign accept    = imem_req & imem_ready;
    assign resp      = pending_q & imem_rvalid;
    assign push      = resp & ~discard_q;
    assign pop       = (count_q != '0) & out_ready;

    assign out_valid    = (count_q != '0);
    assign out_inst     = inst_q[rd_ptr_q];
    assign out_pc       = pc_q[rd_ptr_q];
    assign out_after_pc = apc_q[rd_ptr_q];
    assign count        = count_q;

    // Next-state: redirect flushes everything; otherwise accept, respond, push and pop.
    always_comb begin
        fpc_d     = fpc_q;
        req_pc_d  = req_pc_q;
        pending_d = pending_q;
        discard_d = discard_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        inst_d    = inst_q;
        pc_d      = pc_q;
        apc_d     = apc_q;

        if (redirect) begin
            fpc_d    = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            if (pending_q && !imem_rvalid) begin
                // the in-flight word belongs to the old path; drop it on arrival
                discard_d = 1'b1;
            end else if (pending_q && imem_rvalid) begin
                pending_d = 1'b0;
                discard_d = 1'b0;
            end
        end else begin
            if (resp) begin
                if (discard_q) begin
                    discard_d = 1'b0;
                end
            end
            if (push) begin
                inst_d[wr_ptr_q] = imem_rdata;
                pc_d[wr_ptr_q]   = req_pc_q;
                apc_d[wr_ptr_q]  = req_pc_q + STEP;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (accept) begin
                req_pc_d  = fpc_q;
                fpc_d     = fpc_q + STEP;
                pending_d = 1'b1;
            end else if (resp) begin
                pending_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fpc_q     <= RESET_PC;
            req_pc_q  <= '0;
            pending_q <= 1'b0;
            discard_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
                apc_q[i]  <= '0;
            end
        end else begin
            fpc_q     <= fpc_d;
            req_pc_q  <= req_pc_d;
            pending_q <= pending_d;
            discard_q <= discard_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            apc_q     <= apc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue. A transaction-level model (fetch PC,
// one outstanding request, a queue of {inst, pc, after_pc}) predicts the
// request line and the decode-side outputs every cycle.
module tb_if_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] STEP     = 32'd4;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_after_pc;
    logic [2:0]  count;

    if_fetch_queue #(
        .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_after_pc(out_after_pc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] apc;
    } ent_t;

    ent_t        q[$];
    ent_t        e;
    logic [31:0] m_fpc;
    logic [31:0] m_req_pc;
    bit          m_pend;
    bit          m_disc;
    bit          m_just_reset;
    int          mem_wait;
    int          phase;
    int          wait_pick;
    bit          exp_req;
    bit          accept;
    bit          resp;
    bit          do_pop;

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        m_fpc = RESET_PC; m_req_pc = '0; m_pend = 0; m_disc = 0; q.delete();
        m_just_reset = 1; mem_wait = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            phase = (cyc / 500) % 4;

            rst         = (phase != 0 && $urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            redirect    = 1'b0;
            redirect_pc = $urandom & ~32'h3;
            case (phase)
                0: begin imem_ready = 1'b1; out_ready = 1'b1; wait_pick = 1; end
                1: begin
                    imem_ready = ($urandom_range(0, 1) == 0);
                    out_ready  = ($urandom_range(0, 3) == 0);
                    wait_pick  = $urandom_range(1, 4);
                    redirect   = ($urandom_range(0, 39) == 0);
                end
                2: begin
                    imem_ready = ($urandom_range(0, 3) != 0);
                    out_ready  = ($urandom_range(0, 4) < 3);
                    wait_pick  = $urandom_range(1, 3);
                    redirect   = ($urandom_range(0, 7) == 0);
                end
                default: begin
                    imem_ready = 1'b1;
                    out_ready  = ($urandom_range(0, 1) == 0);
                    wait_pick  = $urandom_range(1, 2);
                    redirect   = ($urandom_range(0, 15) == 0);
                end
            endcase
            case ($urandom_range(0, 3))
                0: redirect_pc = 32'h0000_0100;
                1: redirect_pc = 32'hFFFF_FFF8;
                2: redirect_pc = 32'hFFFF_FFFC;
                default: ;
            endcase

            // memory: answer the outstanding request when its latency expires;
            // otherwise occasionally raise a stray rvalid that must be ignored
            if (m_pend && mem_wait == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(m_req_pc);
            end else if (!m_pend && $urandom_range(0, 3) == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = $urandom;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end

            #1;
            exp_req = rst && !redirect && (q.size() + int'(m_pend) < DEPTH)
                      && (!m_pend || imem_rvalid);
            chk("imem_req",  imem_req,  exp_req);
            chk("imem_addr", imem_addr, m_fpc);
            chk("out_valid", out_valid, q.size() != 0);
            chk("count",     count,     q.size());
            if (q.size() != 0) begin
                chk("out_inst",     out_inst,     q[0].inst);
                chk("out_pc",       out_pc,       q[0].pc);
                chk("out_after_pc", out_after_pc, q[0].apc);
            end else if (m_just_reset) begin
                chk("rst_out_inst",     out_inst,     0);
                chk("rst_out_pc",       out_pc,       0);
                chk("rst_out_after_pc", out_after_pc, 0);
            end

            accept       = exp_req && imem_ready;
            resp         = m_pend && imem_rvalid;
            m_just_reset = 0;
            if (!rst) begin
                m_fpc = RESET_PC; m_pend = 0; m_disc = 0; q.delete();
                m_just_reset = 1;
            end else if (redirect) begin
                q.delete();
                m_fpc = redirect_pc;
                if (m_pend && !imem_rvalid) begin
                    m_disc = 1;
                end else if (m_pend) begin
                    m_pend = 0;
                    m_disc = 0;
                end
            end else begin
                do_pop = (q.size() != 0) && out_ready;
                if (resp) begin
                    if (m_disc) begin
                        m_disc = 0;
                    end else begin
                        e.inst = imem_rdata;
                        e.pc   = m_req_pc;
                        e.apc  = m_req_pc + STEP;
                        q.push_back(e);
                    end
                end
                if (do_pop) void'(q.pop_front());
                if (accept) begin
                    m_req_pc = m_fpc;
                    m_fpc    = m_fpc + STEP;
                    m_pend   = 1;
                end else if (resp) begin
                    m_pend = 0;
                end
            end
            if (accept) mem_wait = wait_pick;
            else if (m_pend && mem_wait > 1) mem_wait--;

            @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
